// File: rtl/fetch_stage.sv
// IF stage with IF/ID register: owns the PC, keeps at most one imem request in flight,
// parks a response in a one-entry skid while ID is stalled, and kills wrong-path fetches.
module fetch_stage #(
    parameter int unsigned         XLEN      = 32,
    parameter logic [XLEN-1:0]     RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_resp_valid_i,
    input  logic [31:0]     imem_resp_data_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [31:0]     if_id_instr_o,
    output logic [4:0]      if_id_rs1_addr_o,
    output logic [4:0]      if_id_rs2_addr_o
);

    typedef enum logic [1:0] {IDLE, WAIT, KILL} state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_t;

    state_e          state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            skid_valid_q, skid_valid_d;
    fetch_t          skid_q, skid_d;
    logic            if_id_valid_q, if_id_valid_d;
    fetch_t          if_id_q, if_id_d;

    logic resp_ok;
    logic req_valid;
    logic req_fire;

    // A response only counts while WAIT; in IDLE it is stale, in KILL it is wrong-path.
    assign resp_ok   = (state_q == WAIT) && imem_resp_valid_i;
    assign req_valid = !rst_i && !redirect_valid_i && !skid_valid_q &&
                       ((state_q == IDLE) || (resp_ok && !stall_i));
    assign req_fire  = req_valid && imem_req_ready_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;

    assign if_id_valid_o    = if_id_valid_q;
    assign if_id_pc_o       = if_id_q.pc;
    assign if_id_instr_o    = if_id_q.instr;
    assign if_id_rs1_addr_o = if_id_q.instr[19:15];
    assign if_id_rs2_addr_o = if_id_q.instr[24:20];

    always_comb begin
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_d        = skid_q;
        if_id_valid_d = if_id_valid_q;
        if_id_d       = if_id_q;

        if (redirect_valid_i) begin
            pc_d = redirect_pc_i;
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (req_fire) begin
            req_pc_d = pc_q;
        end

        if (redirect_valid_i) begin
            skid_valid_d     = 1'b0;
            if_id_valid_d    = 1'b0;
            if_id_d.instr    = NOP_INSTR;
        end else if (stall_i) begin
            // IF/ID frozen; a returning fetch waits in the skid instead of being lost.
            if (resp_ok && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_d       = '{pc: req_pc_q, instr: imem_resp_data_i};
            end
        end else if (skid_valid_q) begin
            if_id_valid_d = 1'b1;
            if_id_d       = skid_q;
            skid_valid_d  = 1'b0;
        end else if (resp_ok) begin
            if_id_valid_d = 1'b1;
            if_id_d       = '{pc: req_pc_q, instr: imem_resp_data_i};
        end else begin
            if_id_valid_d = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (req_fire) state_q <= WAIT;
                WAIT: begin
                    if (imem_resp_valid_i) begin
                        state_q <= req_fire ? WAIT : IDLE;
                    end else if (redirect_valid_i) begin
                        state_q <= KILL;
                    end
                end
                KILL: if (imem_resp_valid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            skid_valid_q  <= 1'b0;
            skid_q        <= '0;
            if_id_valid_q <= 1'b0;
            if_id_q       <= '{pc: '0, instr: NOP_INSTR};
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_q        <= skid_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_q       <= if_id_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural imem plus a scoreboard of expected IF/ID
// contents, pushed when a live response is driven and popped when IF/ID loads.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i = 1'b1;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic [4:0]  if_id_rs1_addr_o;
    logic [4:0]  if_id_rs2_addr_o;

    fetch_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_resp_valid_i(imem_resp_valid_i),
        .imem_resp_data_i (imem_resp_data_i),
        .if_id_valid_o    (if_id_valid_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_instr_o    (if_id_instr_o),
        .if_id_rs1_addr_o (if_id_rs1_addr_o),
        .if_id_rs2_addr_o (if_id_rs2_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    exp_t sb[$];

    // imem model state
    logic        mem_pend = 1'b0, mem_kill = 1'b0, mem_hold = 1'b0, resp_live = 1'b0;
    logic [31:0] mem_addr = '0, resp_addr = '0;
    int          mem_wait = 0, mem_lat = 0;

    // reference model state
    logic [31:0] exp_addr = RPC, exp_pc = '0, exp_instr = NOP;
    logic        exp_v = 1'b0, prev_stall = 1'b0, prev_redir = 1'b0;

    logic        obs_valid, obs_req, obs_hs;
    logic [31:0] obs_pc, obs_instr, obs_addr;

    bit tv  [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    int tpc [11] = '{0, 0, 0, 4, 8, 8, 8, 8, 'hC, 0, 'h10};
    bit treq[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ (a << 13) ^ 32'h00AB_C013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        obs_valid = if_id_valid_o;
        obs_pc    = if_id_pc_o;
        obs_instr = if_id_instr_o;
        obs_req   = imem_req_valid_o;
        obs_addr  = imem_req_addr_o;
        obs_hs    = obs_req & imem_req_ready_i;
        if (rst_i) begin
            chk("rst_req", obs_req, 0);
            chk("rst_valid", obs_valid, 0);
            sb.delete();
            if (mem_pend) mem_kill = 1'b1;
            exp_addr = RPC; exp_v = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
            return;
        end
        if (prev_redir) begin
            chk("redir_bubble", obs_valid, 0);
            exp_v = 1'b0;
        end else if (prev_stall) begin
            chk("hold_valid", obs_valid, exp_v);
            if (exp_v) begin
                chk("hold_pc", obs_pc, exp_pc);
                chk("hold_instr", obs_instr, exp_instr);
            end
        end else begin
            chk("sb_valid", obs_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                pops++;
                chk("sb_pc", obs_pc, e.pc);
                chk("sb_instr", obs_instr, e.instr);
                chk("sb_rs1", if_id_rs1_addr_o, e.instr[19:15]);
                chk("sb_rs2", if_id_rs2_addr_o, e.instr[24:20]);
                exp_v = 1'b1; exp_pc = e.pc; exp_instr = e.instr;
            end else begin
                chk("bubble_instr", obs_instr, NOP);
                exp_v = 1'b0;
            end
        end
        if (imem_resp_valid_i && resp_live && !redirect_valid_i)
            sb.push_back('{pc: resp_addr, instr: instr_of(resp_addr)});
        if (redirect_valid_i) begin
            sb.delete();
            if (mem_pend) mem_kill = 1'b1;
        end
        chk("req_in_redirect", obs_req & redirect_valid_i, 0);
        chk("one_outstanding", obs_hs & mem_pend, 0);
        if (obs_hs) begin
            chk("req_addr", obs_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            mem_pend = 1'b1; mem_addr = obs_addr; mem_wait = mem_lat; mem_kill = 1'b0;
        end
        if (redirect_valid_i) exp_addr = redirect_pc_i;
        prev_stall = stall_i;
        prev_redir = redirect_valid_i;
    endtask

    // Called just after a rising edge: drive imem for this cycle, sample at the falling edge.
    task automatic cyc();
        if (mem_pend && !mem_hold && mem_wait == 0) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_data_i  = instr_of(mem_addr);
            resp_addr         = mem_addr;
            resp_live         = !mem_kill;
            mem_pend          = 1'b0;
        end else begin
            imem_resp_valid_i = 1'b0;
            imem_resp_data_i  = $urandom;
            resp_live         = 1'b0;
            if (mem_pend && !mem_hold) mem_wait--;
        end
        @(negedge clk_i);
        sample();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc);
        bit found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            found = obs_valid;
        end
        chk({tag, "_found"}, found, 1);
        chk({tag, "_pc"}, obs_pc, pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk_i);
        #1;
        chk("reset_valid", if_id_valid_o, 0);
        chk("reset_pc", if_id_pc_o, 0);
        chk("reset_instr", if_id_instr_o, NOP);
        chk("reset_req", imem_req_valid_o, 0);
        chk("reset_rs1", if_id_rs1_addr_o, 0);
        chk("reset_rs2", if_id_rs2_addr_o, 0);
        cyc();
        cyc();

        // stream from reset, then a 3-cycle stall with 0xC in flight
        rst_i = 1'b0;
        for (int t = 0; t < 11; t++) begin
            stall_i = (t >= 4 && t <= 6);
            cyc();
            chk($sformatf("t1_valid_%0d", t), obs_valid, tv[t]);
            if (tv[t]) chk($sformatf("t1_pc_%0d", t), obs_pc, tpc[t]);
            chk($sformatf("t1_req_%0d", t), obs_req, treq[t]);
        end
        stall_i = 1'b0;

        // redirect with a slow fetch outstanding: it must be killed
        mem_lat = 2;
        begin
            bit hs = 0;
            for (int i = 0; i < 10 && !hs; i++) begin
                cyc();
                hs = obs_hs;
            end
            chk("t3_hs_found", hs, 1);
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h100;
        cyc();
        redirect_valid_i = 1'b0;
        mem_lat = 0;
        cyc();
        chk("t3_kill_noreq0", obs_req, 0);
        cyc();
        chk("t3_kill_noreq1", obs_req, 0);
        wait_valid("t3", 32'h100);

        // memory not ready for 4 cycles: address held, bubbles into IF/ID
        imem_req_ready_i = 1'b0;
        cyc();
        cyc();
        chk("t4_drain_valid", obs_valid, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("t4_req_%0d", i), obs_req, 1);
            chk($sformatf("t4_addr_%0d", i), obs_addr, exp_addr);
            chk($sformatf("t4_valid_%0d", i), obs_valid, 0);
            chk($sformatf("t4_instr_%0d", i), obs_instr, NOP);
        end
        imem_req_ready_i = 1'b1;

        // redirect and stall together: redirect wins
        repeat (3) cyc();
        stall_i          = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h200;
        cyc();
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        cyc();
        chk("t5_bubble", obs_valid, 0);
        wait_valid("t5", 32'h200);

        // reset pulsed while a fetch is outstanding; its late response is stale
        mem_hold = 1'b1;
        cyc();
        chk("t6_wait_noreq", obs_req, 0);
        rst_i = 1'b1;
        #1;
        chk("t6_async_valid", if_id_valid_o, 0);
        chk("t6_async_pc", if_id_pc_o, 0);
        chk("t6_async_instr", if_id_instr_o, NOP);
        chk("t6_async_req", imem_req_valid_o, 0);
        cyc();
        rst_i    = 1'b0;
        mem_hold = 1'b0;
        cyc();
        chk("t6_restart_req", obs_hs, 1);
        chk("t6_restart_addr", obs_addr, RPC);
        wait_valid("t6", RPC);
        chk("t6_instr", obs_instr, instr_of(RPC));

        imem_req_ready_i = 1'b0;
        repeat (4) cyc();
        chk("sb_empty", sb.size(), 0);
        chk("sb_pops", pops >= 10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
